// File: rtl/capture_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : capture_pkg
//  Description : Shared opcodes, command FSM states and pad default for the
//                capture sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package capture_pkg;

    localparam logic [7:0] c_op_start  = 8'h01;
    localparam logic [7:0] c_op_stop   = 8'h02;
    localparam logic [7:0] c_op_status = 8'h03;
    localparam logic [7:0] c_op_read   = 8'h04;

    localparam logic [7:0] c_pad_byte  = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LEN  = 2'd1,
        ST_STAT = 2'd2,
        ST_READ = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rsp_stage.sv
`default_nettype none
// ============================================================================
//  Module      : rsp_stage
//  Description : Single-entry valid/ready holding register for response bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
module rsp_stage (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic [7:0] i_load_byte,
    output logic       o_can_load,
    output logic       o_rsp_valid,
    output logic [7:0] o_rsp_byte,
    input  logic       i_rsp_ready
);

    logic       r_valid;
    logic [7:0] r_byte;

    // Byte only changes when empty or being accepted, so it is stable while held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_byte  <= 8'h00;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_byte  <= i_load_byte;
        end else if (r_valid && i_rsp_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_can_load  = !r_valid || i_rsp_ready;
    assign o_rsp_valid = r_valid;
    assign o_rsp_byte  = r_byte;

endmodule
`default_nettype wire

// File: rtl/capture_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : capture_sequencer
//  Description : SPI command decoder controlling microphone capture, status
//                reporting and FIFO read bursts.
//  Revision    : 1.0 - initial release
// ============================================================================
module capture_sequencer #(
    parameter int unsigned FILL_W   = 16,
    parameter logic [7:0]  PAD_BYTE = capture_pkg::c_pad_byte
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    input  logic [7:0]        cmd_byte,
    output logic              rsp_valid,
    output logic [7:0]        rsp_byte,
    input  logic              rsp_ready,
    output logic              capture_en,
    output logic              fifo_rd_en,
    input  logic [7:0]        fifo_rd_data,
    input  logic              fifo_empty,
    input  logic              fifo_full,
    input  logic [FILL_W-1:0] fifo_count,
    output logic              overflow,
    output logic [1:0]        status_led
);
    import capture_pkg::*;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_capture_en;
    logic        r_overflow;
    logic        r_err;
    logic [8:0]  r_remaining;
    logic        r_pending;
    logic        r_pad;
    logic [1:0]  r_stat_ld;
    logic [1:0]  r_stat_acc;
    logic [15:0] r_count_snap;
    logic [15:0] w_count_ext;

    logic        w_can_load;
    logic        w_accept;
    logic        w_load;
    logic [7:0]  w_load_byte;
    logic        w_decide;
    logic        w_cmd_start;
    logic        w_cmd_stop;
    logic        w_cmd_status;
    logic        w_cmd_illegal;
    logic        w_stat_clr;
    logic        w_ovf_set;
    logic        w_ovf_clr;

    always_comb begin
        w_count_ext                = '0;
        w_count_ext[FILL_W-1:0]    = fifo_count;
    end

    assign w_accept   = rsp_valid && rsp_ready;
    assign w_stat_clr = (r_state == ST_STAT) && w_accept && (r_stat_acc == 2'd0);
    assign w_ovf_set  = r_capture_en && fifo_full;
    assign w_ovf_clr  = w_cmd_start || w_stat_clr;

    always_comb begin
        w_state_next  = r_state;
        w_cmd_start   = 1'b0;
        w_cmd_stop    = 1'b0;
        w_cmd_status  = 1'b0;
        w_cmd_illegal = 1'b0;
        w_load        = 1'b0;
        w_load_byte   = 8'h00;
        w_decide      = 1'b0;
        fifo_rd_en    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_byte)
                        c_op_start:  w_cmd_start = 1'b1;
                        c_op_stop:   w_cmd_stop  = 1'b1;
                        c_op_status: begin
                            w_cmd_status = 1'b1;
                            w_state_next = ST_STAT;
                        end
                        c_op_read:   w_state_next = ST_LEN;
                        default:     w_cmd_illegal = 1'b1;
                    endcase
                end
            end
            ST_LEN: begin
                if (cmd_valid) begin
                    w_state_next = ST_READ;
                end
            end
            ST_STAT: begin
                if ((r_stat_ld != 2'd3) && w_can_load) begin
                    w_load = 1'b1;
                    case (r_stat_ld)
                        2'd0:    w_load_byte = {5'b0, r_err, r_overflow, r_capture_en};
                        2'd1:    w_load_byte = r_count_snap[15:8];
                        default: w_load_byte = r_count_snap[7:0];
                    endcase
                end
                if (w_accept && (r_stat_acc == 2'd2)) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_READ: begin
                // A pop is only decided once the stage is sure to be free when its data lands.
                if (r_pending) begin
                    w_load      = 1'b1;
                    w_load_byte = r_pad ? PAD_BYTE : fifo_rd_data;
                end else if ((r_remaining != 9'd0) && w_can_load) begin
                    w_decide   = 1'b1;
                    fifo_rd_en = !fifo_empty;
                end else if ((r_remaining == 9'd0) && w_accept) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_capture_en <= 1'b0;
            r_overflow   <= 1'b0;
            r_err        <= 1'b0;
            r_remaining  <= 9'd0;
            r_pending    <= 1'b0;
            r_pad        <= 1'b0;
            r_stat_ld    <= 2'd0;
            r_stat_acc   <= 2'd0;
            r_count_snap <= 16'h0000;
        end else begin
            r_state <= w_state_next;

            if (w_cmd_start) begin
                r_capture_en <= 1'b1;
            end else if (w_cmd_stop) begin
                r_capture_en <= 1'b0;
            end

            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (w_ovf_clr) begin
                r_overflow <= 1'b0;
            end

            if (w_cmd_illegal) begin
                r_err <= 1'b1;
            end else if (w_stat_clr) begin
                r_err <= 1'b0;
            end

            if (w_cmd_status) begin
                r_count_snap <= w_count_ext;
                r_stat_ld    <= 2'd0;
                r_stat_acc   <= 2'd0;
            end else if (r_state == ST_STAT) begin
                if (w_load) begin
                    r_stat_ld <= r_stat_ld + 2'd1;
                end
                if (w_accept) begin
                    r_stat_acc <= r_stat_acc + 2'd1;
                end
            end

            if ((r_state == ST_LEN) && cmd_valid) begin
                r_remaining <= (cmd_byte == 8'h00) ? 9'd256 : {1'b0, cmd_byte};
            end else if (w_decide) begin
                r_remaining <= r_remaining - 9'd1;
            end

            if (w_decide) begin
                r_pending <= 1'b1;
                r_pad     <= fifo_empty;
            end else begin
                r_pending <= 1'b0;
            end
        end
    end

    rsp_stage u_rsp_stage (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_load),
        .i_load_byte (w_load_byte),
        .o_can_load  (w_can_load),
        .o_rsp_valid (rsp_valid),
        .o_rsp_byte  (rsp_byte),
        .i_rsp_ready (rsp_ready)
    );

    assign capture_en = r_capture_en;
    assign overflow   = r_overflow;
    assign status_led = {r_overflow, r_capture_en};

endmodule
`default_nettype wire

// File: tb/tb_capture_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_capture_sequencer
//  Description : Directed self-checking bench for capture_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_capture_sequencer;

    localparam int FW = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic [7:0]    cmd_byte;
    logic          rsp_valid;
    logic [7:0]    rsp_byte;
    logic          rsp_ready;
    logic          capture_en;
    logic          fifo_rd_en;
    logic [7:0]    fifo_rd_data;
    logic          fifo_empty;
    logic          fifo_full;
    logic [FW-1:0] fifo_count;
    logic          overflow;
    logic [1:0]    status_led;

    int errors = 0;
    int checks = 0;
    int pop_cnt = 0;
    int bad_pop = 0;
    logic [7:0] fifo_q[$];
    logic [7:0] rx_q[$];

    capture_sequencer #(.FILL_W(FW), .PAD_BYTE(8'h00)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_byte     (cmd_byte),
        .rsp_valid    (rsp_valid),
        .rsp_byte     (rsp_byte),
        .rsp_ready    (rsp_ready),
        .capture_en   (capture_en),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .status_led   (status_led)
    );

    always #20 clk = ~clk;

    // FIFO read-side model: data valid the cycle after the pop.
    initial begin
        fifo_rd_data = 8'h00;
        fifo_empty   = 1'b1;
    end
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            pop_cnt++;
            if (fifo_q.size() == 0) bad_pop++;
            else fifo_rd_data <= fifo_q.pop_front();
        end
        fifo_empty <= (fifo_q.size() == 0);
    end

    typedef struct {
        logic       cv;
        logic [7:0] cmd;
        logic       full;
        logic       cap;
        logic       ovf;
    } vec_t;
    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_cmd(input logic [7:0] b);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_byte  = b;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic collect(input int n, input int max_cyc);
        rx_q.delete();
        for (int c = 0; c < max_cyc; c++) begin
            if (rsp_valid && rsp_ready) rx_q.push_back(rsp_byte);
            if (rx_q.size() == n) break;
            @(negedge clk);
        end
    endtask

    task automatic expect_bytes(input string name, input int n, input logic [7:0] b0,
                                input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
        logic [7:0] exp_b[4];
        logic [7:0] got;
        exp_b[0] = b0; exp_b[1] = b1; exp_b[2] = b2; exp_b[3] = b3;
        check({name, "_count"}, rx_q.size(), n);
        for (int i = 0; i < n; i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            check($sformatf("%s_byte%0d", name, i), {24'h0, got}, {24'h0, exp_b[i]});
        end
    endtask

    initial begin
        int p0;
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_byte   = 8'h00;
        rsp_ready  = 1'b1;
        fifo_full  = 1'b0;
        fifo_count = '0;

        //              cv    cmd    full  cap   ovf
        vecs[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
        vecs[4]  = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 8'h01, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 8'h01, 1'b1, 1'b1, 1'b1};
        vecs[8]  = '{1'b1, 8'hFF, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{1'b1, 8'h02, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_byte", rsp_byte, 8'h00);
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_capture_en", capture_en, 0);
        check("rst_overflow", overflow, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            cmd_valid = vecs[i].cv;
            cmd_byte  = vecs[i].cmd;
            fifo_full = vecs[i].full;
            @(negedge clk);
            cmd_valid = 1'b0;
            fifo_full = 1'b0;
            check($sformatf("vec%0d_cap", i), capture_en, vecs[i].cap);
            check($sformatf("vec%0d_ovf", i), overflow, vecs[i].ovf);
            check($sformatf("vec%0d_led", i), status_led, {vecs[i].ovf, vecs[i].cap});
            check($sformatf("vec%0d_rsp", i), rsp_valid, 0);
        end

        // START then full for 3 cycles, then STOP
        send_cmd(8'h01);
        fifo_full = 1'b1;
        repeat (3) @(negedge clk);
        fifo_full = 1'b0;
        check("ovf3_led", status_led, 2'b11);
        send_cmd(8'h02);
        check("stop_cap", capture_en, 0);
        check("stop_ovf", overflow, 1);

        // STATUS with err=1, overflow=1, capture off, count zero-extended
        fifo_count = 12'hFFF;
        send_cmd(8'h03);
        collect(3, 40);
        expect_bytes("stat1", 3, 8'h06, 8'h0F, 8'hFF, 8'h00);
        @(negedge clk);
        check("stat1_ovf_clr", overflow, 0);

        // STATUS with capture on and overflow set
        send_cmd(8'h01);
        fifo_full = 1'b1;
        @(negedge clk);
        fifo_full = 1'b0;
        fifo_count = 12'h123;
        send_cmd(8'h03);
        collect(3, 40);
        expect_bytes("stat2", 3, 8'h03, 8'h01, 8'h23, 8'h00);
        @(negedge clk);
        check("stat2_ovf_clr", overflow, 0);
        check("stat2_cap", capture_en, 1);

        // READ N=4 from a 4-byte FIFO
        fifo_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        p0 = pop_cnt;
        send_cmd(8'h04);
        send_cmd(8'h04);
        collect(4, 60);
        expect_bytes("rd4", 4, 8'hA1, 8'hB2, 8'hC3, 8'hD4);
        repeat (3) @(negedge clk);
        check("rd4_pops", pop_cnt - p0, 4);
        check("rd4_idle_rsp", rsp_valid, 0);

        // READ N=3 with only one byte available
        fifo_q = '{8'h5A};
        p0 = pop_cnt;
        send_cmd(8'h04);
        send_cmd(8'h03);
        collect(3, 60);
        expect_bytes("rd3pad", 3, 8'h5A, 8'h00, 8'h00, 8'h00);
        repeat (3) @(negedge clk);
        check("rd3pad_pops", pop_cnt - p0, 1);

        // READ N=2 with rsp_ready held low
        fifo_q = '{8'h11, 8'h22};
        rsp_ready = 1'b0;
        p0 = pop_cnt;
        send_cmd(8'h04);
        send_cmd(8'h02);
        for (int c = 0; c < 20 && !rsp_valid; c++) @(negedge clk);
        check("rl_valid", rsp_valid, 1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("rl_hold%0d_byte", c), rsp_byte, 8'h11);
            check($sformatf("rl_hold%0d_pops", c), pop_cnt - p0, 1);
        end
        rsp_ready = 1'b1;
        collect(2, 40);
        expect_bytes("rl", 2, 8'h11, 8'h22, 8'h00, 8'h00);
        repeat (3) @(negedge clk);
        check("rl_pops", pop_cnt - p0, 2);

        // illegal opcode is reported in STATUS byte 0
        send_cmd(8'hFF);
        send_cmd(8'h03);
        collect(3, 40);
        expect_bytes("err", 3, 8'h05, 8'h01, 8'h23, 8'h00);

        // reset in the middle of a 4-byte READ
        fifo_q = '{8'h31, 8'h32, 8'h33, 8'h34};
        send_cmd(8'h04);
        send_cmd(8'h04);
        collect(2, 40);
        expect_bytes("rstrd", 2, 8'h31, 8'h32, 8'h00, 8'h00);
        rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_rsp_byte", rsp_byte, 8'h00);
        check("midrst_rd_en", fifo_rd_en, 0);
        check("midrst_cap", capture_en, 0);
        check("midrst_led", status_led, 2'b00);
        fifo_q.delete();
        @(negedge clk);
        p0 = pop_cnt;
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_pops", pop_cnt - p0, 0);
        send_cmd(8'h03);
        collect(3, 40);
        expect_bytes("postrst_stat", 3, 8'h00, 8'h01, 8'h23, 8'h00);

        repeat (2) @(negedge clk);
        check("no_empty_pops", bad_pop, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/capture_sequencer.md
CAPTURE_SEQUENCER -- requirements
Module: capture_sequencer

Interface
REQ-001 Parameter FILL_W, default 16, width of FIFO fill count; SHALL be 9..16.
REQ-002 Parameter PAD_BYTE, default 8'h00, byte returned when a read burst underruns.
REQ-003 clk  input  1  system clock (25 MHz board clock); single clock domain.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 cmd_valid  input  1  one-cycle strobe; SPI slave delivered a received byte.
REQ-006 cmd_byte  input  8  received SPI byte, valid with cmd_valid.
REQ-007 rsp_valid  output  1  response byte available for the SPI slave shift register.
REQ-008 rsp_byte  output  8  response byte; SHALL be stable while rsp_valid=1.
REQ-009 rsp_ready  input  1  SPI slave accepted rsp_byte this cycle when rsp_valid=1.
REQ-010 capture_en  output  1  gates microphone sample writes into the FIFO.
REQ-011 fifo_rd_en  output  1  one-cycle FIFO pop request.
REQ-012 fifo_rd_data  input  8  FIFO output, valid exactly 1 cycle after fifo_rd_en.
REQ-013 fifo_empty, fifo_full  input  1 each  FIFO flags.
REQ-014 fifo_count  input  FILL_W  current FIFO fill in bytes.
REQ-015 overflow  output  1  sticky: FIFO was full while capture_en=1.
REQ-016 status_led  output  2  {overflow, capture_en} for board LEDs.

Function
REQ-017 Opcodes: 8'h01 START, 8'h02 STOP, 8'h03 STATUS, 8'h04 READ (followed by one length byte N), all others ILLEGAL.
REQ-018 Command FSM states: IDLE, LEN, STAT, READ; only IDLE decodes opcodes.
REQ-019 IDLE: START sets capture_en and clears overflow next cycle; STOP clears capture_en next cycle; neither produces a response.
REQ-020 IDLE: STATUS -> STAT; READ -> LEN; ILLEGAL sets sticky err flag, stays IDLE.
REQ-021 LEN: next cmd_valid byte latched as N; N=0 means 256; -> READ.
REQ-022 STAT: emits 3 bytes in order {5'b0, err, overflow, capture_en}, fifo_count[15:8] (zero-extended), fifo_count[7:0]; fifo_count sampled once on STAT entry; err and overflow cleared when byte 0 is accepted; -> IDLE after byte 2 accepted.
REQ-023 READ: emits exactly N bytes; per byte, if fifo_empty=0 assert fifo_rd_en for 1 cycle and present fifo_rd_data as rsp_byte on the following cycle, else present PAD_BYTE without popping; -> IDLE after Nth byte accepted.
REQ-024 At most one FIFO pop outstanding; no pop while rsp_valid=1 and rsp_ready=0; never pop when fifo_empty=1.
REQ-025 rsp_valid rises no earlier than 1 cycle after the pop (or the decision to pad); falls the cycle after acceptance unless the next byte is already staged.
REQ-026 cmd_valid in LEN consumed only as length; cmd_valid in STAT or READ (host dummy bytes) ignored, no state change.
REQ-027 overflow set on any cycle with capture_en=1 and fifo_full=1; clearing (START or STATUS byte 0) loses to a simultaneous set.
REQ-028 capture_en unaffected by READ/STATUS; capture and draining may run concurrently.
REQ-029 fifo_count width FILL_W<16 zero-extended into the two count bytes.

Reset
REQ-030 Asynchronous assertion, state IDLE; capture_en, fifo_rd_en, rsp_valid, overflow, err = 0; rsp_byte = 8'h00.
REQ-031 Reset mid-burst abandons remaining bytes; no pop issued while rst_n=0 or in the first cycle after release.

Structure
REQ-032 Shared package capture_pkg holds opcode localparams, the FSM state enum, and PAD_BYTE default.
REQ-033 One sub-module, rsp_stage: single-entry valid/ready holding register for rsp_byte/rsp_valid.

Verification
REQ-034 START, then fifo_full=1 for 3 cycles -> capture_en=1, overflow=1, status_led=2'b11; STOP -> capture_en=0, overflow stays 1.
REQ-035 STATUS with fifo_count=16'h0123, overflow=1 -> bytes 8'h03, 8'h01, 8'h23 (capture on); overflow=0 after first accept.
REQ-036 READ N=4, FIFO holds A1 B2 C3 D4, rsp_ready always 1 -> A1,B2,C3,D4, exactly 4 fifo_rd_en pulses, return to IDLE.
REQ-037 READ N=3, FIFO holds 1 byte 5A -> 5A,00,00; exactly 1 pop.
REQ-038 READ N=2 with rsp_ready low 10 cycles -> rsp_byte stable, no extra pop; opcode 8'hFF in IDLE -> STATUS byte 0 bit2=1.
REQ-039 rst_n pulsed low mid READ (byte 2 of 4) -> all outputs at reset values immediately; next STATUS answers normally.
